// File: rtl/gpio_arbiter.sv
// gpio_arbiter: two-master round-robin arbiter/sequencer for the GPIO port.
// Optional GPIO_ARB_LOCK_EN enables locked back-to-back access chains.
module gpio_arbiter #(
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              gpio_we,
  output logic [DATA_W-1:0] gpio_wdata,
  input  logic [DATA_W-1:0] gpio_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state;
  logic              sel;
  logic              last;
  logic              win;
  logic              win_we;
  logic [DATA_W-1:0] win_wdata;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic              lock_go;

  // On a tie the master that was not served last wins.
  always_comb begin
    win = 1'b0;
    if (m0_req && m1_req) win = ~last;
    else                  win = m1_req;
  end

  assign win_we    = win ? m1_we : m0_we;
  assign win_wdata = win ? m1_wdata : m0_wdata;
  assign sel_we    = sel ? m1_we : m0_we;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;

`ifdef GPIO_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [CW-1:0] cnt;

  assign lock_go = (state == RESP)
                && (sel ? (m1_lock && m1_req)
                        : (m0_lock && m0_req))
                && (cnt < CW'(LOCK_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (state == ACCESS) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = m0_lock ^ m1_lock;
  assign lock_go     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last       <= 1'b1;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      gpio_we    <= 1'b0;
      gpio_wdata <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state      <= ACCESS;
            busy       <= 1'b1;
            sel        <= win;
            m0_gnt     <= ~win;
            m1_gnt     <= win;
            gpio_we    <= win_we;
            gpio_wdata <= win_wdata;
          end
        end
        ACCESS: begin
          state   <= RESP;
          m0_gnt  <= 1'b0;
          m1_gnt  <= 1'b0;
          gpio_we <= 1'b0;
          last    <= sel;
          if (sel) begin
            m1_rvalid <= 1'b1;
            m1_rdata  <= gpio_rdata;
          end else begin
            m0_rvalid <= 1'b1;
            m0_rdata  <= gpio_rdata;
          end
        end
        RESP: begin
          m0_rvalid <= 1'b0;
          m1_rvalid <= 1'b0;
          if (lock_go) begin
            state      <= ACCESS;
            m0_gnt     <= ~sel;
            m1_gnt     <= sel;
            gpio_we    <= sel_we;
            gpio_wdata <= sel_wdata;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
